fifo_word_packer: RTL
=====================

// Module: fifo_word_packer
// PURPOSE
//  Read side of simple_fifo: pops WIDTH-bit words through its rd/empty/data_out port.
//  Packs RATIO consecutive words into one WIDTH*RATIO-bit word. Presents that word on a
//  valid/ready stream. A flush request emits a partially filled word, with a lane-keep mask.
//  Sits between the FIFO and the wide downstream datapath.
// PARAMETERS
//  WIDTH   8   FIFO word width (bits); must match the feeding FIFO
//  RATIO   4   FIFO words per output word; >= 2
// PORTS
//  clk         in   1            single clock; all logic rising-edge
//  rst         in   1            asynchronous, active-high reset
//  fifo_empty  in   1            FIFO empty flag
//  fifo_data   in   WIDTH        FIFO data_out; show-ahead (valid while !fifo_empty)
//  fifo_rd     out  1            pop strobe to FIFO rd
//  flush       in   1            1-cycle pulse: emit partial word
//  m_valid     out  1            output word valid
//  m_ready     in   1            downstream accepts when m_valid & m_ready
//  m_data      out  WIDTH*RATIO  packed word; lane 0 = first popped word, in LSBs
//  m_keep      out  RATIO        per-lane valid mask; all-ones for full words
//  flush_done  out  1            1-cycle pulse when the flush completes
// BEHAVIOUR
//  Reset (async assert, sync release): state=S_FILL, lane_cnt=0, flush_pend=0.
//   Outputs at reset: fifo_rd=0, m_valid=0, m_data=0, m_keep=0, flush_done=0.
//  Storage: assembly register asm_q holds lanes 0..RATIO-2. Output register out_q is a single entry.
//  out_free = !m_valid | m_ready (output register empty or being drained this cycle).
//  fifo_rd is combinational: !rst & !fifo_empty & state==S_FILL & (lane_cnt<RATIO-1 | out_free).
//  Pop with lane_cnt<RATIO-1: fifo_data -> lane lane_cnt; lane_cnt++.
//  Pop with lane_cnt==RATIO-1: {fifo_data, lanes 0..RATIO-2} -> out_q; m_keep=all-ones;
//   m_valid=1 next cycle; lane_cnt=0.
//  Latency: the last lane's pop to m_valid is 1 cycle. Sustained rate: 1 pop/cycle,
//   1 output per RATIO cycles.
//  m_valid/m_data/m_keep hold stable while m_valid & !m_ready. m_valid is never dropped
//   before acceptance. Accept with no new load: m_valid=0 next cycle; m_data/m_keep hold
//   their last value.
//  fifo_empty from simple_fifo lags writes by 1 cycle. The packer never pops while
//   fifo_empty=1; no other qualification is used.
//  States:
//   S_FILL: normal packing. flush=1 -> S_FLUSH (flush_pend=1). fifo_rd is still honoured
//    in that same cycle.
//   S_FLUSH: fifo_rd=0.
//    lane_cnt==0: nothing to emit; flush_done=1; -> S_FILL.
//    lane_cnt>0 and out_free: load out_q with lanes 0..lane_cnt-1; zero the upper lanes;
//     m_keep=(1<<lane_cnt)-1; lane_cnt=0; flush_done=1; -> S_FILL.
//    Otherwise: wait in S_FLUSH.
//  flush while in S_FLUSH is ignored (no queuing). flush_done pulses exactly once per
//   accepted flush.
//  lane_cnt width = $clog2(RATIO). Counts 0..RATIO-1, then wraps to 0. Never reaches RATIO.
//  Reset mid-word: the partial assembly is discarded, and a pending m_valid word is lost.
//   Downstream must tolerate this.
// STRUCTURE
//  Shared package fifo_pkg: typedef enum logic {S_FILL, S_FLUSH} pack_state_t.
//   fifo_pkg also holds the helper function keep_mask(cnt) -> RATIO-bit mask.
//  Sub-module stream_hold_reg: single-entry valid/ready output register. Parameterised by
//   data width; loads on load & out_free.
//  Top level: lane counter, assembly register, FSM, fifo_rd decode.
// TESTING  (WIDTH=8, RATIO=4, paired with simple_fifo DEPTH=32)
//  1 Push 0x11,0x22,0x33,0x44 with m_ready=1 -> one beat: m_data=0x44332211, m_keep=4'hF;
//    4 pops on 4 consecutive cycles.
//  2 Push 12 words with m_ready=0 -> exactly 7 pops: 4 fill out_q, 3 fill asm lanes 0-2.
//    Raise m_ready -> 3 beats, in order, with no gaps beyond the pop rate.
//  3 Push 0xA1,0xB2 then pulse flush -> m_data=0x0000B2A1, m_keep=4'h3; flush_done 1 cycle.
//    A later full word is unaffected.
//  4 Flush with lane_cnt=0 -> no beat; flush_done next cycle. Flush while out_q is stalled
//    -> waits; no fifo_rd in S_FLUSH.
//  5 Assert rst asynchronously mid-word (lane_cnt=2, m_valid=1) -> outputs 0 before the
//    next clk edge. After release, the next 4 pops form a clean word.
//  6 Random push/m_ready/flush for 10k cycles -> scoreboard byte stream matches. m_data stable
//    while stalled. fifo_rd is never high while fifo_empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// keep_mask returns a low-aligned lane mask; callers size it down to their lane count.
package fifo_pkg;

   typedef enum logic {
      S_FILL  = 1'b0,
      S_FLUSH = 1'b1
   } pack_state_t;

   localparam int MAX_RATIO = 32;

   function automatic logic [MAX_RATIO-1:0] keep_mask(input int cnt);
      logic [MAX_RATIO-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_RATIO; i++) begin
         if (i < cnt) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// Single-entry valid/ready output register.
// Accepts a new word whenever it is empty or its current word is being drained this cycle.
module stream_hold_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   output logic          out_free,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data
);

   assign out_free = !m_valid || m_ready;

   // Data holds its last value after acceptance; only a new load changes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (load && out_free) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops narrow words from a show-ahead FIFO and packs RATIO of them into one wide
// valid/ready beat; a flush emits the partial word with a lane-keep mask.
//
//   state   | meaning
//   S_FILL  | popping FIFO words into lanes; a full word loads the output register
//   S_FLUSH | no pops; waiting for the output register to take the partial word
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   input  logic [WIDTH-1:0]       fifo_data,
   output logic                   fifo_rd,
   input  logic                   flush,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH*RATIO-1:0] m_data,
   output logic [RATIO-1:0]       m_keep,
   output logic                   flush_done
);

   localparam int CW = $clog2(RATIO);
   localparam int OW = WIDTH * RATIO;
   localparam int AW = WIDTH * (RATIO - 1);
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   pack_state_t     state;
   logic [CW-1:0]   lane_cnt;
   logic            flush_pend;
   logic [AW-1:0]   asm_q;

   logic            out_free;
   logic            pop_last;
   logic            flush_load;
   logic            load;
   logic [OW-1:0]   part_word;
   logic [RATIO-1:0] part_keep;
   logic [OW-1:0]   load_data;
   logic [RATIO-1:0] load_keep;

   // The last lane needs the output register free because it completes a word.
   assign fifo_rd = !rst && !fifo_empty && (state == S_FILL) &&
                    ((lane_cnt != LAST) || out_free);

   assign pop_last   = fifo_rd && (lane_cnt == LAST);
   assign flush_load = flush_pend && (lane_cnt != '0) && out_free;
   assign flush_done = flush_pend && ((lane_cnt == '0) || out_free);

   always_comb begin
      part_word = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
         if (CW'(i) < lane_cnt) part_word[i*WIDTH +: WIDTH] = asm_q[i*WIDTH +: WIDTH];
      end
   end

   assign part_keep = RATIO'(keep_mask(int'(lane_cnt)));

   assign load      = pop_last || flush_load;
   assign load_data = pop_last ? {fifo_data, asm_q} : part_word;
   assign load_keep = pop_last ? '1 : part_keep;

   stream_hold_reg #(
      .DW (OW + RATIO)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data ({load_keep, load_data}),
      .out_free  (out_free),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    ({m_keep, m_data})
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FILL;
         lane_cnt   <= '0;
         flush_pend <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               if (fifo_rd) lane_cnt <= (lane_cnt == LAST) ? '0 : lane_cnt + CW'(1);
               if (flush) begin
                  state      <= S_FLUSH;
                  flush_pend <= 1'b1;
               end
            end
            S_FLUSH: begin
               if (flush_done) begin
                  lane_cnt   <= '0;
                  state      <= S_FILL;
                  flush_pend <= 1'b0;
               end
            end
            default: begin
               state      <= S_FILL;
               flush_pend <= 1'b0;
            end
         endcase
      end
   end

   // Lane contents need no reset: lane_cnt and the keep mask decide what is ever emitted.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RATIO - 1; i++) begin
         if (fifo_rd && (lane_cnt == CW'(i))) asm_q[i*WIDTH +: WIDTH] <= fifo_data;
      end
   end

endmodule
